// File: rtl/ex_stage.sv
// ex_stage: OpenMIPS execute stage; ALU, shifts, compares, HI/LO moves and an iterative DIV/DIVU.
// Latency: non-divide ops are combinational (0 cycles); DIV/DIVU take 33 stall cycles (1 if divisor is 0).
// Backpressure: raises stallreq_o while a divide is pending; DONE is held while stall[3] keeps EX frozen. Divider built only with EX_DIV_EN.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b00010011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b00101011;
    localparam logic [7:0] EXE_ADD_OP  = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP  = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP = 8'b00100011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    logic [4:0]  sh_amt;
    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] arith_res;
    logic [31:0] move_res;

    logic        div_stall;
    logic        div_done;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    assign sh_amt = reg1_i[4:0];

    // Single-cycle result for each result class
    always_comb begin
        logic_res = 32'h0;
        shift_res = 32'h0;
        arith_res = 32'h0;
        move_res  = 32'h0;
        case (aluop_i)
            EXE_OR_OP:   logic_res = reg1_i | reg2_i;
            EXE_AND_OP:  logic_res = reg1_i & reg2_i;
            EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
            EXE_SLL_OP:  shift_res = reg2_i << sh_amt;
            EXE_SRL_OP:  shift_res = reg2_i >> sh_amt;
            EXE_SRA_OP:  shift_res = $unsigned($signed(reg2_i) >>> sh_amt);
            EXE_ADD_OP,
            EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
            EXE_SUB_OP,
            EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
            EXE_SLT_OP:  arith_res = {31'h0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: arith_res = {31'h0, reg1_i < reg2_i};
            EXE_MFHI_OP: move_res  = hi_i;
            EXE_MFLO_OP: move_res  = lo_i;
            default: ;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    div_state_t  state, state_nxt;
    logic [31:0] quo;       // dividend shifts out the top, quotient bits shift in
    logic [31:0] rem;       // partial remainder (magnitude)
    logic [31:0] dvs;       // divisor magnitude
    logic [4:0]  cnt;
    logic        q_neg;
    logic        r_neg;
    logic        is_div;
    logic        is_sdiv;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_sh;
    logic        sub_ok;
    logic        unused_stall;

    assign is_div  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign is_sdiv = (aluop_i == EXE_DIV_OP);
    assign a_mag   = (is_sdiv && reg1_i[31]) ? (32'h0 - reg1_i) : reg1_i;
    assign b_mag   = (is_sdiv && reg2_i[31]) ? (32'h0 - reg2_i) : reg2_i;
    assign rem_sh  = {rem, quo[31]};
    assign sub_ok  = (rem_sh >= {1'b0, dvs});
    assign unused_stall = ^{stall[5:4], stall[2:0]};

    // Divider state register and datapath; one restoring step per BUSY cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DIV_IDLE;
            quo   <= 32'h0;
            rem   <= 32'h0;
            dvs   <= 32'h0;
            cnt   <= 5'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                DIV_IDLE: begin
                    if (is_div) begin
                        cnt <= 5'd0;
                        rem <= 32'h0;
                        if (reg2_i != 32'h0) begin
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            q_neg <= is_sdiv & (reg1_i[31] ^ reg2_i[31]);
                            r_neg <= is_sdiv & reg1_i[31];
                        end else begin
                            quo   <= 32'h0;
                            dvs   <= 32'h0;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem <= sub_ok ? (rem_sh[31:0] - dvs) : rem_sh[31:0];
                    quo <= {quo[30:0], sub_ok};
                    cnt <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Divider next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (is_div) state_nxt = (reg2_i != 32'h0) ? DIV_BUSY : DIV_DONE;
            DIV_BUSY: if (cnt == 5'd31) state_nxt = DIV_DONE;
            DIV_DONE: if (!stall[3]) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    assign div_stall = ((state == DIV_IDLE) && is_div) || (state == DIV_BUSY);
    assign div_done  = (state == DIV_DONE);
    assign div_lo    = q_neg ? (32'h0 - quo) : quo;
    assign div_hi    = r_neg ? (32'h0 - rem) : rem;
`else
    logic unused_div;

    assign unused_div = ^{clk, stall};
    assign div_stall  = 1'b0;
    assign div_done   = 1'b0;
    assign div_hi     = 32'h0;
    assign div_lo     = 32'h0;
`endif

    // Output mux; everything is forced to zero while reset is held
    always_comb begin
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'h0;
        whilo_o    = 1'b0;
        hi_o       = 32'h0;
        lo_o       = 32'h0;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i;
            stallreq_o = div_stall;
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                EXE_RES_ARITH: wdata_o = arith_res;
                EXE_RES_MOVE:  wdata_o = move_res;
                default:       wdata_o = 32'h0;
            endcase
            if (div_done) begin
                whilo_o = 1'b1;
                hi_o    = div_hi;
                lo_o    = div_lo;
            end else if (aluop_i == EXE_MTHI_OP) begin
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = lo_i;
            end else if (aluop_i == EXE_MTLO_OP) begin
                whilo_o = 1'b1;
                hi_o    = hi_i;
                lo_o    = reg1_i;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: random ALU ops against a behavioural model, directed divider scenarios.
// Divider checks adapt to whether EX_DIV_EN is defined for the build.
// Outputs sampled 3 time units after the rising edge, inputs driven 2 units after it.
module tb_ex_stage;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'b00100100;
    localparam logic [7:0] OP_OR   = 8'b00100101;
    localparam logic [7:0] OP_XOR  = 8'b00100110;
    localparam logic [7:0] OP_NOR  = 8'b00100111;
    localparam logic [7:0] OP_SLL  = 8'b01111100;
    localparam logic [7:0] OP_SRL  = 8'b00000010;
    localparam logic [7:0] OP_SRA  = 8'b00000011;
    localparam logic [7:0] OP_MFHI = 8'b00010000;
    localparam logic [7:0] OP_MTHI = 8'b00010001;
    localparam logic [7:0] OP_MFLO = 8'b00010010;
    localparam logic [7:0] OP_MTLO = 8'b00010011;
    localparam logic [7:0] OP_SLT  = 8'b00101010;
    localparam logic [7:0] OP_SLTU = 8'b00101011;
    localparam logic [7:0] OP_ADD  = 8'b00100000;
    localparam logic [7:0] OP_ADDU = 8'b00100001;
    localparam logic [7:0] OP_SUB  = 8'b00100010;
    localparam logic [7:0] OP_SUBU = 8'b00100011;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2, hi_in, lo_in;
    logic [4:0]  wd;
    logic        wreg;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, stallreq_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] op_tab  [17];
    logic [2:0] sel_tab [17];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .aluop_i(aluop), .alusel_i(alusel),
        .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .hi_i(hi_in), .lo_i(lo_in),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference register result from the instruction's architectural meaning
    function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
        int sh;
        sh = int'(a % 32);
        case (op)
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLL:  return b << sh;
            OP_SRL:  return b >> sh;
            OP_SRA:  return b[31] ? ~((~b) >> sh) : (b >> sh);
            OP_ADD, OP_ADDU: return a + b;
            OP_SUB, OP_SUBU: return a + (~b) + 32'd1;
            OP_SLT:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            OP_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            OP_MFHI: return h;
            OP_MFLO: return l;
            default: return 32'h0;
        endcase
    endfunction

    // Reference quotient/remainder: truncating division, remainder takes dividend sign
    task automatic ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, qq, rr;
        if (b == 32'h0) begin
            q = 32'h0; r = 32'h0;
        end else if (op == OP_DIVU) begin
            q = a / b; r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa - qq * sb;
            q  = qq[31:0];
            r  = rr[31:0];
        end
    endtask

    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit hold_done);
        logic [31:0] q, r;
        int n;
        ref_div(op, a, b, q, r);
        aluop = op; alusel = 3'b000; reg1 = a; reg2 = b; stall = 6'd0;
        #1;
`ifdef EX_DIV_EN
        n = 0;
        while (stallreq_o === 1'b1 && n < 40) begin
            n++;
            tick();
            #1;
        end
        chk({tag, "_stall_cycles"}, n, (b == 32'h0) ? 32'd1 : 32'd33);
        chk({tag, "_stallreq_done"}, {31'h0, stallreq_o}, 32'd0);
        chk({tag, "_whilo"}, {31'h0, whilo_o}, 32'd1);
        chk({tag, "_lo"}, lo_o, q);
        chk({tag, "_hi"}, hi_o, r);
        if (hold_done) begin
            stall = 6'b001000;
            for (int k = 0; k < 3; k++) begin
                tick();
                #1;
                chk({tag, "_hold_whilo"}, {31'h0, whilo_o}, 32'd1);
                chk({tag, "_hold_lo"}, lo_o, q);
                chk({tag, "_hold_hi"}, hi_o, r);
                chk({tag, "_hold_stallreq"}, {31'h0, stallreq_o}, 32'd0);
            end
            stall = 6'd0;
            tick();
            #1;
            // Back in IDLE with the divide op still presented: a new request appears
            chk({tag, "_idle_restart"}, {31'h0, stallreq_o}, 32'd1);
            chk({tag, "_idle_whilo"}, {31'h0, whilo_o}, 32'd0);
        end
        aluop = OP_NOP;
        #1;
        chk({tag, "_after_stallreq"}, {31'h0, stallreq_o}, 32'd0);
        tick();
`else
        chk({tag, "_nodiv_stallreq"}, {31'h0, stallreq_o}, 32'd0);
        chk({tag, "_nodiv_whilo"}, {31'h0, whilo_o}, 32'd0);
        chk({tag, "_nodiv_wdata"}, wdata_o, 32'h0);
        aluop = OP_NOP;
        tick();
`endif
    endtask

    initial begin
        logic [31:0] a, b, exp_w;
        int k;
        op_tab = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_ADDU,
                   OP_SUB, OP_SUBU, OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
        sel_tab = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100,
                    3'b100, 3'b100, 3'b100, 3'b100, 3'b011, 3'b011, 3'b000, 3'b000};

        rst = 1'b0; stall = 6'd0; aluop = OP_ADDU; alusel = 3'b100;
        reg1 = 32'h1234; reg2 = 32'h5678; wd = 5'd7; wreg = 1'b1;
        hi_in = 32'hAAAA5555; lo_in = 32'h5555AAAA;
        tick(); tick();
        #1;
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_wd", {27'h0, wd_o}, 32'h0);
        chk("rst_wreg", {31'h0, wreg_o}, 32'h0);
        chk("rst_stallreq", {31'h0, stallreq_o}, 32'h0);
        chk("rst_whilo", {31'h0, whilo_o}, 32'h0);
        rst = 1'b1;
        tick();

        // Directed ALU cases
        aluop = OP_ADDU; alusel = 3'b100; reg1 = 32'hFFFFFFFF; reg2 = 32'd2;
        #1;
        chk("addu_wrap", wdata_o, 32'd1);
        chk("addu_stallreq", {31'h0, stallreq_o}, 32'd0);
        aluop = OP_SRA; alusel = 3'b010; reg1 = 32'd4; reg2 = 32'h80000000;
        #1;
        chk("sra_neg", wdata_o, 32'hF8000000);
        aluop = OP_SLT; alusel = 3'b111; reg1 = 32'hFFFFFFFF; reg2 = 32'd1;
        #1;
        chk("bad_sel_zero", wdata_o, 32'h0);
        tick();

        // Random single-cycle ops against the model
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 16);
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            aluop = op_tab[k]; alusel = sel_tab[k]; reg1 = a; reg2 = b;
            hi_in = $urandom; lo_in = $urandom; wd = 5'($urandom); wreg = 1'($urandom);
            #1;
            exp_w = (sel_tab[k] == 3'b000) ? 32'h0 : ref_wdata(op_tab[k], a, b, hi_in, lo_in);
            chk("rnd_wdata", wdata_o, exp_w);
            chk("rnd_wd", {27'h0, wd_o}, {27'h0, wd});
            chk("rnd_wreg", {31'h0, wreg_o}, {31'h0, wreg});
            chk("rnd_stallreq", {31'h0, stallreq_o}, 32'd0);
            chk("rnd_whilo", {31'h0, whilo_o},
                (op_tab[k] == OP_MTHI || op_tab[k] == OP_MTLO) ? 32'd1 : 32'd0);
            if (op_tab[k] == OP_MTHI) begin
                chk("mthi_hi", hi_o, a);
                chk("mthi_lo", lo_o, lo_in);
            end
            if (op_tab[k] == OP_MTLO) begin
                chk("mtlo_hi", hi_o, hi_in);
                chk("mtlo_lo", lo_o, a);
            end
            tick();
        end

        // Divider: directed cases then random ones
        run_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_div("divu_by0", OP_DIVU, 32'd100, 32'd0, 1'b0);
        run_div("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_div("div_hold", OP_DIV, 32'd1000, 32'hFFFFFFF9, 1'b1);
        run_div("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_div("div_rnd", (i < 3) ? OP_DIV : OP_DIVU, a, b, 1'b0);
        end

`ifdef EX_DIV_EN
        // Reset in the middle of a divide abandons it
        aluop = OP_DIVU; alusel = 3'b000; reg1 = 32'hFFFFFFFF; reg2 = 32'd16;
        for (int i = 0; i < 11; i++) tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_stallreq", {31'h0, stallreq_o}, 32'd0);
        chk("mid_rst_lo", lo_o, 32'h0);
        tick();
        #1;
        chk("post_rst_stallreq", {31'h0, stallreq_o}, 32'd0);
        chk("post_rst_whilo", {31'h0, whilo_o}, 32'd0);
        chk("post_rst_hi", hi_o, 32'h0);
        rst = 1'b1;
`endif
        run_div("divu_rerun", OP_DIVU, 32'hFFFFFFFF, 32'd16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
